// File: rtl/mod4051_mult_seq.sv
// Sequential modular multiplier: result = (a * b) mod 4051.
// Each 12-bit operand is split into four 3-bit digits. All 16 digit pairs are
// processed one per cycle through one shared 3x3 product path. Every weighted
// partial product is reduced and then folded into a running residue.
// Optional feature: define MOD4051_MULT_SEQ_ABORT_EN to add an abort input.
// An abort in CALC or HOLD returns the block to IDLE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | 16 digit-pair steps; step counter s selects a_i (s[3:2]), b_j (s[1:0])
// HOLD  | result presented with out_valid high until out_ready
module mod4051_mult_seq #(
  parameter int MODULUS = 4051,
  parameter int DIGIT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*DIGIT_W-1:0] a,
  input  logic [4*DIGIT_W-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*DIGIT_W-1:0] result,
`ifdef MOD4051_MULT_SEQ_ABORT_EN
  output logic                 busy,
  input  logic                 abort
`else
  output logic                 busy
`endif
);

  localparam int OP_W   = 4 * DIGIT_W;
  localparam int PROD_W = 2 * DIGIT_W;
  localparam int WP_W   = PROD_W + OP_W;
  localparam logic [WP_W-1:0] MOD_WP  = WP_W'(MODULUS);
  localparam logic [OP_W:0]   MOD_SUM = (OP_W + 1)'(MODULUS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         step;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    b_q;
  logic [OP_W-1:0]    acc;

  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [2:0]         wt_idx;
  logic [OP_W-1:0]    wt;
  logic [PROD_W-1:0]  prod;
  logic [WP_W-1:0]    wprod;
  logic [OP_W-1:0]    term;
  logic [OP_W:0]      sum;
  logic [OP_W-1:0]    acc_nxt;
  logic               accept;
  logic               abort_req;

  // 2^(3k) mod 4051 for k = 0..6; the only weights any digit pair needs.
  function automatic logic [OP_W-1:0] weight(input logic [2:0] k);
    case (k)
      3'd0:    weight = OP_W'(1);
      3'd1:    weight = OP_W'(8);
      3'd2:    weight = OP_W'(64);
      3'd3:    weight = OP_W'(512);
      3'd4:    weight = OP_W'(45);
      3'd5:    weight = OP_W'(360);
      3'd6:    weight = OP_W'(2880);
      default: weight = OP_W'(0);
    endcase
  endfunction

  // Reset gates in_ready so it is low while reset is held, even though state is IDLE.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign result    = acc;
  assign accept    = in_valid && in_ready;

`ifdef MOD4051_MULT_SEQ_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Shared digit-product path: select digits, weight, reduce, then add modulo.
  always_comb begin
    dig_a   = a_q[int'(step[3:2]) * DIGIT_W +: DIGIT_W];
    dig_b   = b_q[int'(step[1:0]) * DIGIT_W +: DIGIT_W];
    wt_idx  = {1'b0, step[3:2]} + {1'b0, step[1:0]};
    wt      = weight(wt_idx);
    prod    = PROD_W'(dig_a) * PROD_W'(dig_b);
    wprod   = WP_W'(prod) * WP_W'(wt);
    term    = OP_W'(wprod % MOD_WP);
    sum     = {1'b0, acc} + {1'b0, term};
    acc_nxt = (sum >= MOD_SUM) ? OP_W'(sum - MOD_SUM) : OP_W'(sum);
  end

  // Next-state logic; abort overrides every non-IDLE transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (step == 4'd15) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, step counter and accumulator.
  // The accumulator is kept after HOLD exits so result keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      step <= '0;
    end else if (abort_req) begin
      acc  <= '0;
      step <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      step <= '0;
    end else if (state == CALC) begin
      acc  <= acc_nxt;
      step <= step + 4'd1;
    end
  end

endmodule

// File: doc/mod4051_mult_seq.md
MOD4051_MULT_SEQ -- requirements
Module: mod4051_mult_seq

Interface
REQ-001 The block SHALL have parameter MODULUS, default 4051, the fixed modulus; no other value is supported.
REQ-002 The block SHALL have parameter DIGIT_W, default 3, the digit width in bits; operands are 4 digits wide.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 The block SHALL have port a, input, 12 bits: multiplicand, any value 0..4095.
REQ-008 The block SHALL have port b, input, 12 bits: multiplier, any value 0..4095.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, 12 bits: (a*b) mod 4051, always in the range 0..4050.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and HOLD.
REQ-014 in_ready SHALL equal 1 only in IDLE.
REQ-015 An operand pair SHALL be accepted when in_valid and in_ready are both high at a rising edge; a and b are latched and the FSM moves IDLE->CALC.
REQ-016 CALC SHALL last exactly 16 cycles, driven by a 4-bit step counter s = 0..15; each step uses digit i = s[3:2] of a and digit j = s[1:0] of b (digit 0 = bits 2:0).
REQ-017 Each step SHALL add the term (a_i * b_j * 2^(3*(i+j))) mod 4051 to a 12-bit accumulator, with the sum reduced mod 4051 in the same cycle.
REQ-018 The accumulator SHALL be cleared on acceptance and SHALL stay in the range 0..4050 after every step.
REQ-019 Weight factors 2^(3k) mod 4051 for k = 0..6 SHALL be constants; one 3x3 digit product is formed per cycle and that product path is shared across all steps.
REQ-020 After step 15 the FSM SHALL enter HOLD, with out_valid = 1 and result = the final accumulator value; latency is 16 cycles from the accepting edge to out_valid high.
REQ-021 In HOLD, result SHALL be stable while out_valid is high and out_ready is low, for any number of cycles.
REQ-022 HOLD SHALL move to IDLE on out_valid and out_ready both high; out_valid then falls and result holds its last value.
REQ-023 in_valid SHALL be ignored outside IDLE; no new pair is accepted in the same cycle as a HOLD->IDLE exit, so the minimum issue interval is 18 cycles.
REQ-024 Changes on a and b after acceptance SHALL NOT affect the current result.
REQ-025 The step counter SHALL wrap 15->0 on entry to HOLD.

Reset
REQ-026 Assertion of rst_n = 0 SHALL asynchronously force state to IDLE, and out_valid, result, busy, the accumulator, the step counter and the operand registers to 0, at any point including mid-CALC or mid-HOLD.
REQ-027 With rst_n = 0, in_ready SHALL be 0; it SHALL be 1 in the first cycle after reset deassertion.
REQ-028 A computation interrupted by reset SHALL produce no out_valid.

Configuration
REQ-029 Macro MOD4051_MULT_SEQ_ABORT_EN SHALL, when defined, add input abort (1 bit); abort = 1 at an edge in CALC or HOLD returns the FSM to IDLE, clears out_valid and the accumulator, and is ignored in IDLE.
REQ-030 When MOD4051_MULT_SEQ_ABORT_EN is undefined, the abort port SHALL NOT exist and behaviour SHALL be exactly as in REQ-013 to REQ-028.

Verification
REQ-031 Bench: a=100, b=100 accepted -> out_valid exactly 16 cycles later, result = 1898.
REQ-032 Bench: a=4050, b=4050 -> result = 1; a=4095, b=1 -> result = 44; a=2, b=2048 -> result = 45.
REQ-033 Bench: a=0, b=1234 -> result = 0; then hold out_ready=0 for 10 cycles -> out_valid and result stay stable, in_ready = 0 throughout.
REQ-034 Bench: in_valid held high continuously with out_ready=1 -> one accept every 18 cycles; in_valid pulsed during CALC -> ignored.
REQ-035 Bench: rst_n pulsed low at CALC step 7 -> all outputs 0 immediately, in_ready=1 after release, next pair a=7, b=7 -> result = 49.
REQ-036 Bench (with ABORT_EN): abort at CALC step 3 -> IDLE next cycle with no out_valid; abort in HOLD -> out_valid drops; following a=4095, b=4095 -> result = 1936.
